// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the serial-to-word shift controller.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Counter must be able to hold WIDTH (the parity slot when parity is enabled).
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_reg_bidir.sv
// WIDTH-bit shift register with synchronous clear; shifts left (new bit at LSB)
// or right (new bit at MSB) when enabled.
module shift_reg_bidir
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             dir,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      if (dir == DIR_RIGHT) q <= {d, q[WIDTH-1:1]};
      else                  q <= {q[WIDTH-2:0], d};
    end
  end

endmodule

// File: rtl/shift_ctrl.sv
// Frame sequencer: gathers WIDTH serial bits into a word and offers it on valid/ready.
// Optional macro SHIFT_CTRL_PARITY_EN adds a trailing even-parity bit and parity_err output.
module shift_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             overrun
`ifdef SHIFT_CTRL_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(WIDTH);
`ifdef SHIFT_CTRL_PARITY_EN
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
`else
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`endif

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             dir_q;
  logic             sr_clr;
  logic             sr_en;

  // Data bits only; the parity slot (count == WIDTH) never enters the register.
  always_comb begin
    sr_clr = 1'b0;
    sr_en  = 1'b0;
    case (state)
      IDLE:    sr_clr = start;
      SHIFT:   sr_en  = bit_valid && (count < DATA_CNT);
      HOLD:    sr_clr = word_ready && start;
      default: sr_clr = 1'b0;
    endcase
  end

  shift_reg_bidir #(.WIDTH(WIDTH)) u_sreg (
    .clk (clk),
    .rst (rst),
    .clr (sr_clr),
    .en  (sr_en),
    .dir (dir_q),
    .d   (bit_in),
    .q   (word_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      dir_q      <= DIR_LEFT;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
`ifdef SHIFT_CTRL_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SHIFT;
            dir_q   <= dir;
            count   <= '0;
            overrun <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (bit_valid) begin
            if (count == LAST_CNT) begin
              state      <= HOLD;
              word_valid <= 1'b1;
`ifdef SHIFT_CTRL_PARITY_EN
              parity_err <= (^word_out) ^ bit_in;
`endif
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bit_valid) overrun <= 1'b1;
          if (word_ready) begin
            word_valid <= 1'b0;
            if (start) begin
              state   <= SHIFT;
              dir_q   <= dir;
              count   <= '0;
              overrun <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl; parity scenario compiled in with SHIFT_CTRL_PARITY_EN.
module tb_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dir;
  logic       bit_valid;
  logic       bit_in;
  logic [7:0] word_out;
  logic       word_valid;
  logic       word_ready;
  logic       busy;
  logic       overrun;
`ifdef SHIFT_CTRL_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;

  shift_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dir        (dir),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .overrun    (overrun)
`ifdef SHIFT_CTRL_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    step();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic begin_frame(input logic d);
    start = 1'b1;
    dir   = d;
    step();
    start = 1'b0;
    dir   = 1'b0;
  endtask

  // Serial order: data[7] first. Appends the even-parity bit when enabled.
  task automatic feed(input logic [7:0] data);
    for (int i = 7; i >= 0; i--) send_bit(data[i]);
`ifdef SHIFT_CTRL_PARITY_EN
    send_bit(^data);
`endif
  endtask

  task automatic handshake();
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++;
    if (word_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || word_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got vld=%b busy=%b ovr=%b word=%h want 0 0 0 00",
               word_valid, busy, overrun, word_out);
    end
    rst = 1'b0;
    begin_frame(1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (word_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || word_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_midframe got vld=%b busy=%b ovr=%b word=%h want 0 0 0 00",
               word_valid, busy, overrun, word_out);
    end
    begin_frame(1'b0);
    feed(8'hC3);
    checks++;
    if (word_valid !== 1'b1 || word_out !== 8'hC3) begin
      errors++;
      $display("FAIL reset_recover got vld=%b word=%h want 1 c3", word_valid, word_out);
    end
    handshake();
  endtask

  task automatic test_left();
    begin_frame(1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL left_busy got %b want 1", busy);
    end
    for (int i = 7; i >= 1; i--) send_bit(8'hB2 >> i);
`ifdef SHIFT_CTRL_PARITY_EN
    send_bit(1'b0);
    send_bit(1'b0);
`else
    checks++;
    if (word_valid !== 1'b0) begin
      errors++;
      $display("FAIL left_early_valid got %b want 0", word_valid);
    end
    send_bit(1'b0);
`endif
    checks++;
    if (word_valid !== 1'b1 || word_out !== 8'hB2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL left_word got vld=%b word=%h busy=%b want 1 b2 1", word_valid, word_out, busy);
    end
    handshake();
    checks++;
    if (word_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL left_idle got vld=%b busy=%b want 0 0", word_valid, busy);
    end
  endtask

  task automatic test_right_gaps();
    logic [7:0] bits;
    bits = 8'hB2;
    begin_frame(1'b1);
    for (int i = 7; i >= 0; i--) begin
      send_bit(bits[i]);
      step();
      if (i > 0) begin
        checks++;
        if (word_valid !== 1'b0) begin
          errors++;
          $display("FAIL right_early_valid bit=%0d got %b want 0", 8 - i, word_valid);
        end
      end
    end
`ifdef SHIFT_CTRL_PARITY_EN
    send_bit(^bits);
`endif
    checks++;
    if (word_valid !== 1'b1 || word_out !== 8'h4D) begin
      errors++;
      $display("FAIL right_word got vld=%b word=%h want 1 4d", word_valid, word_out);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    // bit_valid while idle must be ignored
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    checks++;
    if (overrun !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_bits got ovr=%b busy=%b want 0 0", overrun, busy);
    end
    begin_frame(1'b0);
    feed(8'h5A);
    send_bit(1'b1);
    for (int i = 0; i < 5; i++) begin
      if (word_out !== 8'h5A || word_valid !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable got %0d unstable cycles (last word=%h vld=%b) want 0",
               bad, word_out, word_valid);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got %b want 1", overrun);
    end
    handshake();
    checks++;
    if (overrun !== 1'b1 || word_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overrun_sticky got ovr=%b vld=%b busy=%b want 1 0 0", overrun, word_valid, busy);
    end
    begin_frame(1'b0);
    checks++;
    if (overrun !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL overrun_clear got ovr=%b busy=%b want 0 1", overrun, busy);
    end
    feed(8'h00);
    handshake();
  endtask

  task automatic test_back_to_back();
    begin_frame(1'b0);
    feed(8'h0F);
    word_ready = 1'b1;
    start      = 1'b1;
    dir        = 1'b1;
    step();
    word_ready = 1'b0;
    start      = 1'b0;
    dir        = 1'b0;
    checks++;
    if (busy !== 1'b1 || word_valid !== 1'b0 || dut.state !== 2'd1) begin
      errors++;
      $display("FAIL b2b_restart got busy=%b vld=%b state=%0d want 1 0 1", busy, word_valid, dut.state);
    end
    // start/dir mid-frame must be ignored: data 8'h80 right-shifted gives 01
    start = 1'b1;
    dir   = 1'b0;
    feed(8'hFF);
    start = 1'b0;
    checks++;
    if (word_valid !== 1'b1 || word_out !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_word got vld=%b word=%h want 1 ff", word_valid, word_out);
    end
    handshake();
    begin_frame(1'b1);
    start = 1'b1;
    feed(8'h80);
    start = 1'b0;
    checks++;
    if (word_valid !== 1'b1 || word_out !== 8'h01) begin
      errors++;
      $display("FAIL shift_ignores_start got vld=%b word=%h want 1 01", word_valid, word_out);
    end
    handshake();
  endtask

`ifdef SHIFT_CTRL_PARITY_EN
  task automatic test_parity();
    logic [7:0] bits;
    bits = 8'hB2;
    begin_frame(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(bits[i]);
    checks++;
    if (word_valid !== 1'b0) begin
      errors++;
      $display("FAIL parity_wait got vld=%b want 0", word_valid);
    end
    send_bit(1'b0);
    checks++;
    if (word_valid !== 1'b1 || word_out !== 8'hB2 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_good got vld=%b word=%h perr=%b want 1 b2 0", word_valid, word_out, parity_err);
    end
    handshake();
    begin_frame(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(bits[i]);
    send_bit(1'b1);
    checks++;
    if (word_valid !== 1'b1 || parity_err !== 1'b1) begin
      errors++;
      $display("FAIL parity_bad got vld=%b perr=%b want 1 1", word_valid, parity_err);
    end
    handshake();
  endtask
`endif

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    dir        = 1'b0;
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    word_ready = 1'b0;
    #2;
    test_reset();
    test_left();
    test_right_gaps();
    test_backpressure();
    test_back_to_back();
`ifdef SHIFT_CTRL_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
